// File: rtl/mc_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_core_ctrl
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning PC, IR, load data and WB strobe.
// Optional perf counters (perf_cycle/perf_instret): define MC_CORE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_core_ctrl #(
  parameter int          XLEN    = 64,
  parameter logic [63:0] PC_RST  = 64'h8000_0000,
  parameter int          TMO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  output logic            lsu_we,
  input  logic            lsu_rsp_valid,
  input  logic [XLEN-1:0] lsu_rsp_data,
  input  logic            dec_is_load,
  input  logic            dec_mem_wen,
  input  logic            dec_reg_wen,
  input  logic            dec_is_jal,
  input  logic            dec_is_jalr,
  input  logic            dec_is_branch,
  input  logic            dec_is_ebreak,
  input  logic            dec_not_ipl,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            reg_wen_o,
  output logic [1:0]      reg_wdata_sel,
  output logic [XLEN-1:0] load_data,
  output logic            retire,
  output logic            halted,
  output logic            trap,
  output logic [1:0]      trap_cause
`ifdef MC_CORE_CTRL_PERF_EN
  ,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  localparam logic [2:0] c_ST_FETCH  = 3'd0;
  localparam logic [2:0] c_ST_WAIT_I = 3'd1;
  localparam logic [2:0] c_ST_EXEC   = 3'd2;
  localparam logic [2:0] c_ST_MEM    = 3'd3;
  localparam logic [2:0] c_ST_WAIT_M = 3'd4;
  localparam logic [2:0] c_ST_WB     = 3'd5;
  localparam logic [2:0] c_ST_HALT   = 3'd6;
  localparam logic [2:0] c_ST_TRAP   = 3'd7;

  localparam logic [1:0] c_CAUSE_ILL = 2'd1;
  localparam logic [1:0] c_CAUSE_TMO = 2'd2;
  localparam logic [1:0] c_CAUSE_MIS = 2'd3;

  localparam int              c_TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic [XLEN-1:0] c_PC_RST   = PC_RST[XLEN-1:0];

  logic [2:0]      state_q, state_d;
  logic [1:0]      cause_q, cause_d;
  logic [XLEN-1:0] pc_q, load_q, next_pc_w;
  logic [31:0]     inst_q;
  logic [c_TW-1:0] tmo_q;
  logic            waiting_w, tmo_hit_w, misalign_w, retire_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    next_pc_w = pc_q + XLEN'(4);
    if (dec_is_jal || dec_is_jalr)          next_pc_w = alu_result & ~XLEN'(1);
    else if (dec_is_branch && alu_result[0]) next_pc_w = pc_q + imm;
  end

  // Only IALIGN=32 is supported, so bit1 of the target is the misalignment flag.
  assign misalign_w = next_pc_w[1];
  assign waiting_w  = (state_q == c_ST_WAIT_I) || (state_q == c_ST_WAIT_M);
  assign tmo_hit_w  = (TMO_CYC != 0) && waiting_w && (tmo_q == c_TMO_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      c_ST_FETCH:  if (ifu_req_ready) state_d = c_ST_WAIT_I;
      c_ST_WAIT_I: begin
        if (ifu_rsp_valid) state_d = c_ST_EXEC;
        else if (tmo_hit_w) begin
          state_d = c_ST_TRAP;
          cause_d = c_CAUSE_TMO;
        end
      end
      c_ST_EXEC: begin
        if (dec_not_ipl) begin
          state_d = c_ST_TRAP;
          cause_d = c_CAUSE_ILL;
        end else if (dec_is_ebreak)             state_d = c_ST_HALT;
        else if (dec_is_load || dec_mem_wen)    state_d = c_ST_MEM;
        else                                    state_d = c_ST_WB;
      end
      c_ST_MEM:    if (lsu_req_ready) state_d = c_ST_WAIT_M;
      c_ST_WAIT_M: begin
        if (lsu_rsp_valid) state_d = c_ST_WB;
        else if (tmo_hit_w) begin
          state_d = c_ST_TRAP;
          cause_d = c_CAUSE_TMO;
        end
      end
      c_ST_WB: begin
        if (misalign_w) begin
          state_d = c_ST_TRAP;
          cause_d = c_CAUSE_MIS;
        end else state_d = c_ST_FETCH;
      end
      c_ST_HALT:   state_d = c_ST_HALT;
      c_ST_TRAP:   state_d = c_ST_TRAP;
      default:     state_d = c_ST_FETCH;
    endcase
  end

  always_comb begin
    ifu_req_valid = (state_q == c_ST_FETCH) && !rst;
    lsu_req_valid = (state_q == c_ST_MEM);
    lsu_we        = (state_q == c_ST_MEM) && dec_mem_wen;
    retire_w      = (state_q == c_ST_WB) && !misalign_w;
    reg_wen_o     = retire_w && dec_reg_wen;
    halted        = (state_q == c_ST_HALT);
    trap          = (state_q == c_ST_TRAP);
    reg_wdata_sel = 2'd0;
    if (dec_is_jal || dec_is_jalr) reg_wdata_sel = 2'd2;
    else if (dec_is_load)          reg_wdata_sel = 2'd1;
  end

  // Counter restarts from zero on every entry into a wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= c_PC_RST;
      inst_q  <= '0;
      load_q  <= '0;
      cause_q <= '0;
      tmo_q   <= '0;
    end else begin
      cause_q <= cause_d;
      tmo_q   <= waiting_w ? tmo_q + c_TW'(1) : '0;
      if ((state_q == c_ST_WAIT_I) && ifu_rsp_valid) inst_q <= ifu_rsp_inst;
      if ((state_q == c_ST_WAIT_M) && lsu_rsp_valid && dec_is_load) load_q <= lsu_rsp_data;
      if (retire_w) pc_q <= next_pc_w;
    end
  end

  assign ifu_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign load_data  = load_q;
  assign retire     = retire_w;
  assign trap_cause = cause_q;

`ifdef MC_CORE_CTRL_PERF_EN
  logic [63:0] perf_cycle_q, perf_instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      if ((state_q != c_ST_HALT) && (state_q != c_ST_TRAP)) perf_cycle_q <= perf_cycle_q + 64'd1;
      if (retire_w) perf_instret_q <= perf_instret_q + 64'd1;
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core_ctrl
// Randomized self-checking bench for mc_core_ctrl acting as bus slaves and decoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_core_ctrl;
  localparam int          XLEN   = 64;
  localparam int          TMO    = 4;
  localparam logic [63:0] PC_RST = 64'h8000_0000;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_JAL = 3, K_JALR = 4, K_BR = 5,
                 K_EBRK = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_addr, lsu_rsp_data, alu_result, imm, pc, load_data;
  logic [31:0] ifu_rsp_inst, inst;
  logic lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
  logic dec_is_load, dec_mem_wen, dec_reg_wen, dec_is_jal, dec_is_jalr, dec_is_branch;
  logic dec_is_ebreak, dec_not_ipl;
  logic reg_wen_o, retire, halted, trap;
  logic [1:0] reg_wdata_sel, trap_cause;
`ifdef MC_CORE_CTRL_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  mc_core_ctrl #(.XLEN(XLEN), .PC_RST(PC_RST), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .dec_is_load(dec_is_load), .dec_mem_wen(dec_mem_wen), .dec_reg_wen(dec_reg_wen),
    .dec_is_jal(dec_is_jal), .dec_is_jalr(dec_is_jalr), .dec_is_branch(dec_is_branch),
    .dec_is_ebreak(dec_is_ebreak), .dec_not_ipl(dec_not_ipl),
    .alu_result(alu_result), .imm(imm), .pc(pc), .inst(inst),
    .reg_wen_o(reg_wen_o), .reg_wdata_sel(reg_wdata_sel), .load_data(load_data),
    .retire(retire), .halted(halted), .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CORE_CTRL_PERF_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] m_pc, m_ld;
  int unsigned m_ret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = '0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_data = '0;
    dec_is_load = 0; dec_mem_wen = 0; dec_reg_wen = 0; dec_is_jal = 0; dec_is_jalr = 0;
    dec_is_branch = 0; dec_is_ebreak = 0; dec_not_ipl = 0;
    alu_result = '0; imm = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(negedge clk);
    chk("rst_pc", pc, PC_RST);
    chk("rst_inst", inst, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_strobes", {ifu_req_valid, lsu_req_valid, retire, reg_wen_o, halted, trap}, 0);
    rst = 0;
    m_pc = PC_RST; m_ld = '0; m_ret = 0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_req", {ifu_req_valid, lsu_req_valid, retire}, 0);
    end
  endtask

  task automatic run_instr(input int kind, input logic [63:0] alu, input logic [63:0] immv,
                           input int dreq, input int drsp, input int dmreq, input int dmrsp,
                           input bit spur, input bit tmo);
    logic [63:0] tgt, ld;
    logic [31:0] iw;
    bit ok, mis, is_mem, rw;
    int cyc;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ifu_req_valid) ok = 1;
      else @(negedge clk);
    end
    chk("fetch_seen", ok, 1);
    if (!ok) return;
    chk("ifu_addr", ifu_addr, m_pc);
    cyc = 0;
    for (int i = 0; i < dreq; i++) begin
      @(negedge clk); cyc++;
      chk("req_hold_v", ifu_req_valid, 1);
      chk("req_hold_a", ifu_addr, m_pc);
    end
    ifu_req_ready = 1;
    if (spur) begin ifu_rsp_valid = 1; ifu_rsp_inst = 32'hDEAD_BEEF; end
    @(negedge clk); cyc++;
    ifu_req_ready = 0; ifu_rsp_valid = 0;
    chk("req_drop", ifu_req_valid, 0);
    is_mem = (kind == K_LD) || (kind == K_ST);
    rw = (kind == K_ALU) || (kind == K_LD) || (kind == K_JAL) || (kind == K_JALR);
    dec_is_load = (kind == K_LD) || (kind == K_ILL);
    dec_mem_wen = (kind == K_ST);
    dec_reg_wen = rw;
    dec_is_jal = (kind == K_JAL);
    dec_is_jalr = (kind == K_JALR);
    dec_is_branch = (kind == K_BR);
    dec_is_ebreak = (kind == K_EBRK) || (kind == K_ILL);
    dec_not_ipl = (kind == K_ILL);
    alu_result = alu; imm = immv;
    for (int i = 0; i < drsp; i++) begin @(negedge clk); cyc++; end
    iw = $urandom;
    ifu_rsp_valid = 1; ifu_rsp_inst = iw;
    @(negedge clk); cyc++;
    ifu_rsp_valid = 0;
    chk("inst", inst, iw);
    @(negedge clk); cyc++;
    if (kind == K_ILL) begin
      chk("ill_trap", {halted, trap}, 2'b01);
      chk("ill_cause", trap_cause, 1);
      return;
    end
    if (kind == K_EBRK) begin
      chk("ebrk_halt", {halted, trap}, 2'b10);
      return;
    end
    ld = {$urandom, $urandom};
    if (is_mem) begin
      chk("lsu_valid", lsu_req_valid, 1);
      chk("lsu_we", lsu_we, kind == K_ST);
      for (int i = 0; i < dmreq; i++) begin
        @(negedge clk); cyc++;
        chk("lsu_hold", lsu_req_valid, 1);
      end
      lsu_req_ready = 1;
      @(negedge clk); cyc++;
      lsu_req_ready = 0;
      chk("lsu_drop", lsu_req_valid, 0);
      if (tmo) begin
        for (int i = 0; i < TMO - 1; i++) begin
          @(negedge clk);
          chk("tmo_wait", {trap, retire}, 0);
        end
        @(negedge clk);
        chk("tmo_trap", trap, 1);
        chk("tmo_cause", trap_cause, 2);
        lsu_rsp_valid = 1; lsu_rsp_data = ld;
        @(negedge clk);
        lsu_rsp_valid = 0;
        chk("late_rsp", {trap, retire, reg_wen_o}, 3'b100);
        chk("late_pc", pc, m_pc);
        chk("late_ld", load_data, m_ld);
        return;
      end
      for (int i = 0; i < dmrsp; i++) begin @(negedge clk); cyc++; end
      lsu_rsp_valid = 1; lsu_rsp_data = ld;
      @(negedge clk); cyc++;
      lsu_rsp_valid = 0;
    end
    if (kind == K_LD) m_ld = ld;
    if (kind == K_JAL || kind == K_JALR) tgt = {alu[63:1], 1'b0};
    else if (kind == K_BR && alu[0])      tgt = m_pc + immv;
    else                                  tgt = m_pc + 64'd4;
    mis = tgt[1];
    chk("cycles", cyc, 3 + dreq + drsp + (is_mem ? 2 + dmreq + dmrsp : 0));
    chk("retire", retire, !mis);
    chk("reg_wen", reg_wen_o, !mis && rw);
    chk("wdata_sel", reg_wdata_sel,
        (kind == K_JAL || kind == K_JALR) ? 2 : (kind == K_LD) ? 1 : 0);
    chk("load_data", load_data, m_ld);
    @(negedge clk);
    if (mis) begin
      chk("mis_trap", trap, 1);
      chk("mis_cause", trap_cause, 3);
      chk("mis_pc", pc, m_pc);
    end else begin
      m_pc = tgt; m_ret++;
      chk("next_pc", pc, m_pc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, v;
    logic [63:0] a, im;
    clear_inputs();
    do_reset();
    run_instr(K_ALU, 64'h1234, 64'h0, 0, 0, 0, 0, 0, 0);
    chk("t1_pc", pc, 64'h8000_0004);
    run_instr(K_ALU, 64'h0, 64'h0, 3, 2, 0, 0, 1, 0);
    run_instr(K_JAL, 64'h8000_0011, 64'h0, 0, 0, 0, 0, 0, 0);
    chk("jal_pc", pc, 64'h8000_0010);
    run_instr(K_BR, 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 0, 0);
    chk("beq_taken", pc, 64'h8000_0008);
    run_instr(K_JAL, 64'h8000_0010, 64'h0, 0, 0, 0, 0, 0, 0);
    run_instr(K_BR, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 0, 0);
    chk("beq_not", pc, 64'h8000_0014);
    run_instr(K_LD, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0);
    run_instr(K_ST, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(K_ALU, K_BR);
      a = {$urandom, $urandom};
      if (k == K_JAL || k == K_JALR) a[1] = 1'b0;
      v = int'($urandom_range(0, 64)) * 4 - 128;
      im = {{32{v[31]}}, v};
      run_instr(k, a, im, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 1), 0);
    end
    run_instr(K_LD, 64'h0, 64'h0, 0, 1, 1, 0, 0, 1);
    idle_check(4);
    // Reset while a fetch response is outstanding.
    do_reset();
    ifu_req_ready = 1;
    @(negedge clk);
    ifu_req_ready = 0;
    do_reset();
    run_instr(K_JALR, 64'h8000_0103, 64'h0, 0, 0, 0, 0, 0, 0);
    idle_check(3);
    do_reset();
    run_instr(K_ILL, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0);
    idle_check(3);
    do_reset();
    run_instr(K_ALU, 64'h0, 64'h0, 1, 0, 0, 0, 0, 0);
    run_instr(K_LD, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0);
    run_instr(K_EBRK, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0);
`ifdef MC_CORE_CTRL_PERF_EN
    a = perf_cycle;
    chk("instret_halt", perf_instret, m_ret);
`endif
    idle_check(8);
    chk("halt_hold", {halted, trap}, 2'b10);
`ifdef MC_CORE_CTRL_PERF_EN
    chk("instret_frozen", perf_instret, m_ret);
    chk("cycle_frozen", perf_cycle, a);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
